// File: rtl/skid_hold_pkg.sv
// Shared types and default widths for the skid_hold_buffer block.
package skid_hold_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_BUSY  = 2'b01,
        S_FULL  = 2'b10
    } state_e;

endpackage : skid_hold_pkg

// File: rtl/sat_stall_counter.sv
// Saturating event counter with a synchronous clear that wins over increment.
module sat_stall_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule : sat_stall_counter

// File: rtl/skid_hold_buffer.sv
// Two-entry valid/ready skid buffer with a downstream stall counter.
// Define SKID_HOLD_STABLE_SVA_EN to compile in the protocol-stability assertions.
module skid_hold_buffer
    import skid_hold_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire, out_fire, stall;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign stall    = out_valid & ~out_ready;
    assign out_data = main_q;

    // State and datapath registers; handshake flags are decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            in_ready  <= (state_d != S_FULL);
            out_valid <= (state_d != S_EMPTY);
        end
    end

    // Next-state and data steering; the skid entry is only used under backpressure.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = S_FULL;
                end else if (out_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = S_BUSY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    sat_stall_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (stall),
        .clr  (stall_clr),
        .cnt  (stall_cnt)
    );

`ifdef SKID_HOLD_STABLE_SVA_EN
    // Masks the first cycle after reset, before in_ready has had a chance to rise.
    logic sva_armed;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sva_armed <= 1'b0;
        else        sva_armed <= 1'b1;
    end

    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)))
        $display("%0t a_out_stable pass", $time);
    else
        $error("%0t a_out_stable: out_valid=%0b out_data=%0h", $time, out_valid, out_data);

    a_in_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && !in_ready) |=> (in_valid && $stable(in_data)))
        $display("%0t a_in_stable pass", $time);
    else
        $error("%0t a_in_stable: in_valid=%0b in_data=%0h", $time, in_valid, in_data);

    a_ready_when_room: assert property (@(posedge clk) disable iff (!rst_n)
        (sva_armed && (state_q != S_FULL)) |-> in_ready)
        $display("%0t a_ready_when_room pass", $time);
    else
        $error("%0t a_ready_when_room: state=%0d in_ready=%0b", $time, state_q, in_ready);
`endif

endmodule : skid_hold_buffer

// File: tb/tb_skid_hold_buffer.sv
// Directed bench for skid_hold_buffer: queue-based reference model plus literal checks.
module tb_skid_hold_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        out_ready = 1'b0;
    logic        stall_clr = 1'b0;

    logic        in_ready, out_valid;
    logic [7:0]  out_data;
    logic [15:0] stall_cnt;
    logic        in_ready4, out_valid4;
    logic [7:0]  out_data4;
    logic [3:0]  stall_cnt4;

    int checks = 0;
    int failures = 0;

    // Reference model: the buffer is a FIFO of capacity two.
    logic [7:0] mq[$];
    logic [7:0] got[$];
    logic       m_in_ready = 1'b0;
    int         m_cnt = 0;
    int         m_cnt4 = 0;

    always #5 clk = ~clk;

    skid_hold_buffer #(.DATA_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .stall_clr(stall_clr), .stall_cnt(stall_cnt)
    );

    skid_hold_buffer #(.DATA_W(8), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .stall_clr(stall_clr), .stall_cnt(stall_cnt4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_in_ready = 1'b0;
            m_cnt      = 0;
            m_cnt4     = 0;
        end else begin
            automatic bit fi = in_valid && m_in_ready;
            automatic bit fo = (mq.size() != 0) && out_ready;
            automatic bit st = (mq.size() != 0) && !out_ready;
            if (fo) void'(mq.pop_front());
            if (fi) mq.push_back(in_data);
            m_in_ready = (mq.size() < 2);
            if (stall_clr) begin
                m_cnt  = 0;
                m_cnt4 = 0;
            end else if (st) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        automatic bit mv = (mq.size() != 0);
        check("in_ready", 32'(in_ready), 32'(m_in_ready));
        check("out_valid", 32'(out_valid), 32'(mv));
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        check("in_ready4", 32'(in_ready4), 32'(m_in_ready));
        check("out_valid4", 32'(out_valid4), 32'(mv));
        check("stall_cnt4", 32'(stall_cnt4), 32'(m_cnt4));
        if (mv) begin
            check("out_data", 32'(out_data), 32'(mq[0]));
            check("out_data4", 32'(out_data4), 32'(mq[0]));
        end
        if (out_valid && out_ready) got.push_back(out_data);
    end

    initial begin
        // Reset held to 12ns
        #12;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        rst_n = 1'b1;
        step();
        check("ready_after_rst", 32'(in_ready), 32'h1);

        // Streaming with out_ready high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h11; step();
        check("stream_11", 32'(out_data), 32'h11);
        in_data   = 8'h22; step();
        check("stream_22", 32'(out_data), 32'h22);
        check("stream_ready", 32'(in_ready), 32'h1);
        in_data   = 8'h33; step();
        check("stream_33", 32'(out_data), 32'h33);
        in_valid  = 1'b0; step();
        check("stream_drained", 32'(out_valid), 32'h0);

        // Backpressure fills both entries
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5; step();
        check("bp_first", 32'(out_data), 32'hA5);
        in_data   = 8'h5A; step();
        check("bp_full_ready", 32'(in_ready), 32'h0);
        check("bp_hold_a5", 32'(out_data), 32'hA5);
        in_data   = 8'h3C; step();
        check("bp_3c_refused", 32'(out_data), 32'hA5);
        check("bp_still_full", 32'(in_ready), 32'h0);
        got.delete();
        out_ready = 1'b1;
        step();
        check("bp_drain_5a", 32'(out_data), 32'h5A);
        step();
        check("bp_drain_3c", 32'(out_data), 32'h3C);
        in_valid = 1'b0;
        step();
        check("bp_order_n", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            check("bp_order_0", 32'(got[0]), 32'hA5);
            check("bp_order_1", 32'(got[1]), 32'h5A);
            check("bp_order_2", 32'(got[2]), 32'h3C);
        end

        // Stall counter: five stalls, clear during a stall, then saturation
        stall_clr = 1'b1; step(); stall_clr = 1'b0;
        check("cnt_cleared", 32'(stall_cnt), 32'h0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h44; step();
        in_valid  = 1'b0;
        repeat (5) step();
        check("cnt_five", 32'(stall_cnt), 32'd5);
        check("cnt4_five", 32'(stall_cnt4), 32'd5);
        stall_clr = 1'b1; step(); stall_clr = 1'b0;
        check("cnt_clr_wins", 32'(stall_cnt), 32'd0);
        repeat (20) step();
        check("cnt_twenty", 32'(stall_cnt), 32'd20);
        check("cnt4_saturated", 32'(stall_cnt4), 32'd15);
        out_ready = 1'b1; step();
        check("cnt_drained", 32'(out_valid), 32'h0);

        // Async reset while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h77; step();
        in_data   = 8'h88; step();
        in_valid  = 1'b0; step();
        check("full_77", 32'(out_data), 32'h77);
        check("full_not_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_out_data", 32'(out_data), 32'h0);
        check("arst_in_ready", 32'(in_ready), 32'h0);
        check("arst_stall_cnt", 32'(stall_cnt), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            step();
            check("post_rst_empty", 32'(out_valid), 32'h0);
        end
        in_valid = 1'b1;
        in_data  = 8'h99; step();
        in_valid = 1'b0;
        check("post_rst_99", 32'(out_data), 32'h99);
        step();
        check("post_rst_drain", 32'(out_valid), 32'h0);
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_skid_hold_buffer
